// File: rtl/voice_mix_scheduler_if.sv
// rtl/voice_mix_scheduler_if.sv - voice sample fetch handshake bundle
interface voice_mix_scheduler_if #(
    parameter int NVOICE = 4,
    parameter int DW     = 16
);
    logic [NVOICE-1:0]    sample_req;
    logic                 sample_chan;
    logic [NVOICE-1:0]    sample_ack;
    logic [NVOICE*DW-1:0] sample_data;

    modport master (
        output sample_req,
        output sample_chan,
        input  sample_ack,
        input  sample_data
    );

    modport slave (
        input  sample_req,
        input  sample_chan,
        output sample_ack,
        output sample_data
    );
endinterface

// File: rtl/voice_mix_scheduler.sv
// rtl/voice_mix_scheduler.sv - per-half-frame voice poller, saturating mixer and bitcrusher
module voice_mix_scheduler #(
    parameter int NVOICE     = 4,
    parameter int DW         = 16,
    parameter int CRUSH_BITS = 8,
    parameter int ACK_TMO    = 64
) (
    input  logic                  clk_50,
    input  logic                  rst,
    input  logic                  daclrck,
    input  logic [NVOICE-1:0]     voice_en,
    input  logic                  bitcrush,
    voice_mix_scheduler_if.master bus,
    output logic [DW-1:0]         Din,
    output logic                  busy,
    output logic                  overrun,
    output logic [NVOICE-1:0]     ack_timeout
);
    localparam int AW = DW + $clog2(NVOICE);
    localparam int VW = $clog2(NVOICE + 1);
    localparam int TW = $clog2(ACK_TMO + 1);
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
    localparam logic [DW-1:0] CMASK = {DW{1'b1}} << CRUSH_BITS;

    typedef enum logic [2:0] {IDLE, NEXT, REQ, SAT, OUT} state_t;

    state_t                 state;
    logic                   s1, s2, s3;
    logic                   lrck_edge;
    logic [VW-1:0]          v;
    logic [TW-1:0]          tmo;
    logic [NVOICE-1:0]      en_q;
    logic                   crush_q;
    logic                   chan_q;
    logic signed [AW-1:0]   acc;
    logic [DW-1:0]          res_q;

    logic                   en_v;
    logic                   ack_v;
    logic signed [DW-1:0]   slice;
    logic [NVOICE-1:0]      onehot;
    logic [DW-1:0]          sat_val;

    assign lrck_edge = s2 ^ s3;
    assign busy      = (state != IDLE);

    // Per-voice selection by compare rather than variable index keeps v's extra
    // terminal count bit out of the select path.
    always_comb begin
        en_v   = 1'b0;
        ack_v  = 1'b0;
        slice  = '0;
        onehot = '0;
        for (int i = 0; i < NVOICE; i++) begin
            if (v == VW'(i)) begin
                en_v      = en_q[i];
                ack_v     = bus.sample_ack[i];
                slice     = bus.sample_data[i*DW +: DW];
                onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sat_val = acc[DW-1:0];
        if (acc > SMAX)
            sat_val = SMAX[DW-1:0];
        else if (acc < SMIN)
            sat_val = SMIN[DW-1:0];
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state           <= IDLE;
            s1              <= 1'b0;
            s2              <= 1'b0;
            s3              <= 1'b0;
            v               <= '0;
            tmo             <= '0;
            en_q            <= '0;
            crush_q         <= 1'b0;
            chan_q          <= 1'b0;
            acc             <= '0;
            res_q           <= '0;
            Din             <= '0;
            overrun         <= 1'b0;
            ack_timeout     <= '0;
            bus.sample_req  <= '0;
            bus.sample_chan <= 1'b0;
        end else begin
            s1 <= daclrck;
            s2 <= s1;
            s3 <= s2;
            // A late edge is only flagged; the running scan owns the frame.
            if (lrck_edge && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (lrck_edge) begin
                        en_q    <= voice_en;
                        crush_q <= bitcrush;
                        chan_q  <= s2;
                        acc     <= '0;
                        v       <= '0;
                        state   <= NEXT;
                    end
                end
                NEXT: begin
                    if (v == VW'(NVOICE)) begin
                        state <= SAT;
                    end else if (!en_v) begin
                        v <= v + 1'b1;
                    end else begin
                        tmo             <= '0;
                        bus.sample_req  <= onehot;
                        bus.sample_chan <= chan_q;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (ack_v) begin
                        acc            <= acc + AW'(slice);
                        v              <= v + 1'b1;
                        bus.sample_req <= '0;
                        state          <= NEXT;
                    end else if (tmo == TW'(ACK_TMO - 1)) begin
                        ack_timeout    <= ack_timeout | onehot;
                        v              <= v + 1'b1;
                        bus.sample_req <= '0;
                        state          <= NEXT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                SAT: begin
                    res_q <= crush_q ? (sat_val & CMASK) : sat_val;
                    state <= OUT;
                end
                OUT: begin
                    Din   <= res_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
